window_address_generation_unit: RTL and testbench

Parametrised register-window address generation unit. It translates local register addresses from the decoder into physical register-file addresses, using an internally held current window pointer (CWP) instead of an externally supplied status-register value. It sits between instruction decode and the register file. It adds window save/restore with automatic spill on overflow and fill on underflow through a word-serial handshake to the data memory port.

---
 rtl/window_address_generation_unit.sv | 151 +++++++++++++++
 tb/tb_window_address_generation_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/window_address_generation_unit.sv
// Register-window address generation unit: maps local register addresses onto a
// windowed physical register file and sequences spill/fill transfers on overflow/underflow.
module window_address_generation_unit #(
  parameter int LOC_W      = 4,
  parameter int N_GLOB     = 8,
  parameter int NWIN       = 16,
  parameter int WIN_STRIDE = 4,
  parameter int CWP_W      = 4,
  parameter int PHYS_W     = 7
) (
  input  logic              clk,
  input  logic              a_reset,
  input  logic [LOC_W-1:0]  l_r_addr_a,
  input  logic [LOC_W-1:0]  l_r_addr_b,
  input  logic [LOC_W-1:0]  l_w_addr,
  output logic [PHYS_W-1:0] r_addr_a,
  output logic [PHYS_W-1:0] r_addr_b,
  output logic [PHYS_W-1:0] w_addr,
  input  logic              win_save,
  input  logic              win_restore,
  output logic [CWP_W-1:0]  cwp,
  output logic              busy,
  output logic              cmd_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [PHYS_W-1:0] mem_addr,
  input  logic              mem_ack
);

  localparam int REG = NWIN * WIN_STRIDE;
  localparam int K_W = (WIN_STRIDE > 1) ? $clog2(WIN_STRIDE) : 1;
  localparam logic [K_W-1:0]   K_LAST  = K_W'(WIN_STRIDE - 1);
  localparam logic [CWP_W-1:0] RES_MAX = CWP_W'(NWIN - 1);

  typedef enum logic [1:0] {IDLE, SPILL, FILL} state_t;

  state_t             state_q, state_d;
  logic [CWP_W-1:0]   owp;
  logic [CWP_W-1:0]   resident;
  logic [K_W-1:0]     k;
  logic [CWP_W-1:0]   fill_win;
  logic               ack, last_ack, illegal;
  logic               do_save, do_restore;

  function automatic logic [PHYS_W-1:0] xlate(input logic [LOC_W-1:0] l,
                                               input logic [CWP_W-1:0] w);
    int off;
    if (int'(l) < N_GLOB) return PHYS_W'(l);
    off = (int'(w) * WIN_STRIDE + int'(l) - N_GLOB) % REG;
    return PHYS_W'(N_GLOB + off);
  endfunction

  function automatic logic [PHYS_W-1:0] word_addr(input logic [CWP_W-1:0] w,
                                                   input logic [K_W-1:0]   kk);
    return PHYS_W'(N_GLOB + (int'(w) * WIN_STRIDE + int'(kk)) % REG);
  endfunction

  assign r_addr_a = xlate(l_r_addr_a, cwp);
  assign r_addr_b = xlate(l_r_addr_b, cwp);
  assign w_addr   = xlate(l_w_addr, cwp);

  // The window being filled is the one just below the current pointer.
  assign fill_win   = cwp - CWP_W'(1);
  assign ack        = mem_req & mem_ack;
  assign last_ack   = ack & (k == K_LAST);
  assign do_save    = win_save & ~win_restore;
  assign do_restore = win_restore & ~win_save;
  assign illegal    = busy ? (win_save | win_restore) : (win_save & win_restore);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge a_reset) begin
    if (a_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (do_save && resident == RES_MAX)            state_d = SPILL;
        else if (do_restore && resident == '0)         state_d = FILL;
      end
      SPILL, FILL: if (last_ack) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  always_ff @(posedge clk or posedge a_reset) begin
    if (a_reset) begin
      cwp      <= '0;
      owp      <= '0;
      resident <= '0;
      k        <= '0;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      cmd_err  <= 1'b0;
    end else begin
      cmd_err <= illegal;
      case (state_q)
        IDLE: begin
          if (do_save) begin
            if (resident == RES_MAX) begin
              k        <= '0;
              mem_req  <= 1'b1;
              mem_we   <= 1'b1;
              mem_addr <= word_addr(owp, '0);
            end else begin
              cwp      <= cwp + CWP_W'(1);
              resident <= resident + CWP_W'(1);
            end
          end else if (do_restore) begin
            if (resident == '0) begin
              k        <= '0;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= word_addr(fill_win, '0);
            end else begin
              cwp      <= fill_win;
              resident <= resident - CWP_W'(1);
            end
          end
        end
        SPILL, FILL: begin
          if (last_ack) begin
            mem_req <= 1'b0;
            k       <= '0;
            if (state_q == SPILL) begin
              cwp <= cwp + CWP_W'(1);
              owp <= owp + CWP_W'(1);
            end else begin
              cwp <= fill_win;
              owp <= owp - CWP_W'(1);
            end
          end else if (ack) begin
            k        <= k + K_W'(1);
            mem_addr <= word_addr((state_q == SPILL) ? owp : fill_win, k + K_W'(1));
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_window_address_generation_unit.sv
// Self-checking bench for window_address_generation_unit: directed scenarios plus
// randomized save/restore traffic against an arithmetic window model.
module tb_window_address_generation_unit;

  localparam int LOC_W = 4, N_GLOB = 8, NWIN = 16, WIN_STRIDE = 4, CWP_W = 4, PHYS_W = 7;
  localparam int REG = NWIN * WIN_STRIDE;

  logic              clk = 1'b0;
  logic              a_reset = 1'b1;
  logic [LOC_W-1:0]  l_r_addr_a = '0, l_r_addr_b = '0, l_w_addr = '0;
  logic [PHYS_W-1:0] r_addr_a, r_addr_b, w_addr;
  logic              win_save = 1'b0, win_restore = 1'b0;
  logic [CWP_W-1:0]  cwp;
  logic              busy, cmd_err, mem_req, mem_we;
  logic [PHYS_W-1:0] mem_addr;
  logic              mem_ack = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  // Model: windows as plain integers.
  int m_cwp = 0, m_owp = 0, m_res = 0;

  window_address_generation_unit #(
    .LOC_W(LOC_W), .N_GLOB(N_GLOB), .NWIN(NWIN),
    .WIN_STRIDE(WIN_STRIDE), .CWP_W(CWP_W), .PHYS_W(PHYS_W)
  ) dut (
    .clk(clk), .a_reset(a_reset),
    .l_r_addr_a(l_r_addr_a), .l_r_addr_b(l_r_addr_b), .l_w_addr(l_w_addr),
    .r_addr_a(r_addr_a), .r_addr_b(r_addr_b), .w_addr(w_addr),
    .win_save(win_save), .win_restore(win_restore),
    .cwp(cwp), .busy(busy), .cmd_err(cmd_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int xlate_ref(input int l, input int w);
    int window_base;
    if (l < N_GLOB) return l;
    window_base = (w * WIN_STRIDE) % REG;
    return N_GLOB + (window_base + (l - N_GLOB)) % REG;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    a_reset = 1'b1;
    step();
    a_reset = 1'b0;
    m_cwp = 0; m_owp = 0; m_res = 0;
    #1;
  endtask

  task automatic check_xlate();
    l_r_addr_a = LOC_W'($urandom);
    l_r_addr_b = LOC_W'($urandom);
    l_w_addr   = LOC_W'($urandom);
    #1;
    check("r_addr_a", int'(r_addr_a), xlate_ref(int'(l_r_addr_a), m_cwp));
    check("r_addr_b", int'(r_addr_b), xlate_ref(int'(l_r_addr_b), m_cwp));
    check("w_addr",   int'(w_addr),   xlate_ref(int'(l_w_addr), m_cwp));
  endtask

  // Runs a spill/fill already started at the previous edge, acking each word
  // after 'delay' idle cycles; optionally issues a save while busy.
  task automatic transfer(input bit spill, input int delay, input bit poke);
    int base_w = spill ? m_owp : (m_cwp + NWIN - 1) % NWIN;
    check("busy_enter", int'(busy), 1);
    check("req_enter", int'(mem_req), 1);
    for (int kk = 0; kk < WIN_STRIDE; kk++) begin
      int exp_addr = N_GLOB + (base_w * WIN_STRIDE + kk) % REG;
      for (int d = 0; d < delay; d++) begin
        bit poked = poke && kk == 1 && d == 0;
        check("hold_addr", int'(mem_addr), exp_addr);
        check("hold_req", int'(mem_req), 1);
        check("hold_we", int'(mem_we), int'(spill));
        win_save = poked;
        step();
        win_save = 1'b0;
        check("busy_cmd_err", int'(cmd_err), int'(poked));
      end
      check("xfer_addr", int'(mem_addr), exp_addr);
      check("xfer_we", int'(mem_we), int'(spill));
      check("xfer_req", int'(mem_req), 1);
      check("old_cwp", int'(cwp), m_cwp);
      check("old_win_addr", int'(r_addr_a), xlate_ref(int'(l_r_addr_a), m_cwp));
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      check("ack_cmd_err", int'(cmd_err), 0);
    end
    if (spill) begin
      m_cwp = (m_cwp + 1) % NWIN;
      m_owp = (m_owp + 1) % NWIN;
    end else begin
      m_cwp = (m_cwp + NWIN - 1) % NWIN;
      m_owp = (m_owp + NWIN - 1) % NWIN;
    end
    check("busy_exit", int'(busy), 0);
    check("req_exit", int'(mem_req), 0);
    check("cwp_after_xfer", int'(cwp), m_cwp);
  endtask

  task automatic command(input bit s, input bit r, input int delay, input bit poke);
    win_save = s; win_restore = r;
    step();
    win_save = 1'b0; win_restore = 1'b0;
    if (s && r) begin
      check("both_cmd_err", int'(cmd_err), 1);
      check("both_cwp", int'(cwp), m_cwp);
      check("both_busy", int'(busy), 0);
    end else if (s && m_res < NWIN - 1) begin
      m_cwp = (m_cwp + 1) % NWIN; m_res++;
      check("save_cwp", int'(cwp), m_cwp);
      check("save_busy", int'(busy), 0);
    end else if (s) begin
      transfer(1'b1, delay, poke);
    end else if (r && m_res > 0) begin
      m_cwp = (m_cwp + NWIN - 1) % NWIN; m_res--;
      check("restore_cwp", int'(cwp), m_cwp);
      check("restore_busy", int'(busy), 0);
    end else if (r) begin
      transfer(1'b0, delay, poke);
    end
    step();
    check("idle_cmd_err", int'(cmd_err), 0);
    check_xlate();
  endtask

  initial begin
    do_reset();
    check("rst_cwp", int'(cwp), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_cmd_err", int'(cmd_err), 0);
    check("rst_mem_req", int'(mem_req), 0);
    check("rst_mem_we", int'(mem_we), 0);
    check("rst_mem_addr", int'(mem_addr), 0);
    l_r_addr_a = 4'd3; l_w_addr = 4'd8; #1;
    check("glob_r_a", int'(r_addr_a), 3);
    check("glob_w_8", int'(w_addr), 8);

    // Stride, wrap and overflow spill.
    command(1'b1, 1'b0, 0, 1'b0);
    l_r_addr_b = 4'd8; #1;
    check("stride_r_b", int'(r_addr_b), 12);
    for (int i = 1; i < 15; i++) command(1'b1, 1'b0, 0, 1'b0);
    check("cwp_15", int'(cwp), 15);
    l_w_addr = 4'd15; #1;
    check("wrap_w", int'(w_addr), 11);
    command(1'b1, 1'b0, 0, 1'b0);
    check("spill_cwp0", int'(cwp), 0);
    l_r_addr_a = 4'd8; #1;
    check("spill_r_a", int'(r_addr_a), 8);

    // Underflow fill straight after reset.
    do_reset();
    command(1'b0, 1'b1, 0, 1'b0);
    check("fill_cwp15", int'(cwp), 15);

    // Delayed acks with a command issued while busy.
    do_reset();
    for (int i = 0; i < 15; i++) command(1'b1, 1'b0, 0, 1'b0);
    command(1'b1, 1'b0, 3, 1'b1);
    command(1'b1, 1'b1, 0, 1'b0);

    // Reset in the middle of a spill.
    do_reset();
    for (int i = 0; i < 15; i++) command(1'b1, 1'b0, 0, 1'b0);
    win_save = 1'b1;
    step();
    win_save = 1'b0;
    check("mid_busy", int'(busy), 1);
    mem_ack = 1'b1;
    step();
    step();
    mem_ack = 1'b0;
    a_reset = 1'b1;
    #1;
    check("abort_req", int'(mem_req), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_cwp", int'(cwp), 0);
    step();
    a_reset = 1'b0;
    m_cwp = 0; m_owp = 0; m_res = 0;
    #1;
    command(1'b1, 1'b0, 0, 1'b0);
    check("post_abort_cwp", int'(cwp), 1);

    // Randomized traffic, alternating save-heavy and restore-heavy phases.
    for (int blk = 0; blk < 8; blk++) begin
      int bias = (blk % 2 == 0) ? 80 : 20;
      for (int i = 0; i < 40; i++) begin
        int sel = $urandom_range(0, 99);
        int dly = $urandom_range(0, 3);
        bit pk  = (dly > 0) && ($urandom_range(0, 3) == 0);
        if (sel < 5)              command(1'b1, 1'b1, dly, pk);
        else if (sel < 5 + bias)  command(1'b1, 1'b0, dly, pk);
        else                      command(1'b0, 1'b1, dly, pk);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
